// File: rtl/spi_xcvr.sv
// SPI master transceiver: one word per transfer, selectable CPOL/CPHA, optional CS hold between words.
// Define SPI_LOOPBACK_EN to add the lpbk input, which feeds the receive sampler from the mosi register.
module spi_xcvr #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        cs_sel,
    input  logic [1:0]        mode,
    input  logic              hold_cs,
    input  logic              release_cs,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic              lpbk
`endif
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDG_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [EDG_W-1:0] EDG_LAST = EDG_W'(2 * DATA_W - 1);
    localparam logic [3:0]       NUM_CS_L = 4'(NUM_CS);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, HOLD, TRAIL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [EDG_W-1:0]    r_edges;
    logic [2:0]          r_cs;
    logic                r_cpha;
    logic                r_hold;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;
    logic                r_done;
    logic                r_err;

    logic                w_cs_ok;
    logic                w_half_end;
    logic                w_last_edge;
    logic                w_lead;
    logic                w_toggle;
    logic                w_sample;
    logic                w_shift;
    logic                w_mosi_nxt;
    logic                w_sin;
    logic [DATA_W-1:0]   w_rx_nxt;
    logic                w_accept;
    logic                w_relatch;
    logic                w_reject;

    assign w_cs_ok     = ({1'b0, cs_sel} < NUM_CS_L);
    assign w_half_end  = (r_cnt == CNT_LAST);
    assign w_last_edge = (r_edges == EDG_LAST);
    // Even-numbered toggles move sclk away from CPOL (leading), odd ones return it (trailing).
    assign w_lead      = ~r_edges[0];
    assign w_toggle    = (r_state == XFER) && w_half_end;
    assign w_sample    = w_toggle && (w_lead != r_cpha);
    assign w_shift     = w_toggle && (w_lead == r_cpha) && !(!r_cpha && w_last_edge);
    assign w_mosi_nxt  = r_cpha ? r_tx[DATA_W-1] : r_tx[DATA_W-2];
    assign w_rx_nxt    = {r_rx_sh[DATA_W-2:0], w_sin};

`ifdef SPI_LOOPBACK_EN
    assign w_sin = lpbk ? r_mosi : miso;
`else
    assign w_sin = miso;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_relatch   = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_cs_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = LEAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            LEAD:  if (w_half_end) w_state_nxt = XFER;
            XFER:  if (w_half_end && w_last_edge) w_state_nxt = r_hold ? HOLD : TRAIL;
            HOLD: begin
                if (release_cs) begin
                    w_state_nxt = TRAIL;
                end else if (start) begin
                    if (cs_sel == r_cs) begin
                        w_relatch   = 1'b1;
                        w_state_nxt = XFER;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            TRAIL: if (w_half_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_edges   <= '0;
            r_cs      <= '0;
            r_cpha    <= 1'b0;
            r_hold    <= 1'b0;
            r_tx      <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= '1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;

            if (r_state inside {IDLE, HOLD} || w_half_end || w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_cs    <= cs_sel;
                r_cpha  <= mode[0];
                r_hold  <= hold_cs;
                r_tx    <= tx_data;
                r_mosi  <= tx_data[DATA_W-1];
                r_sclk  <= mode[1];
                r_cs_n  <= ~(NUM_CS'(1) << cs_sel);
                r_edges <= '0;
            end else if (w_relatch) begin
                r_cpha  <= mode[0];
                r_hold  <= hold_cs;
                r_tx    <= tx_data;
                r_mosi  <= tx_data[DATA_W-1];
                r_edges <= '0;
            end else if (w_toggle) begin
                r_sclk  <= ~r_sclk;
                r_edges <= r_edges + 1'b1;
                if (w_shift) begin
                    r_mosi <= w_mosi_nxt;
                    r_tx   <= r_tx << 1;
                end
            end

            if (w_sample) r_rx_sh <= w_rx_nxt;

            // With CPHA=1 the final sample lands on the same edge that ends XFER.
            if (r_state == XFER && w_state_nxt != XFER) begin
                r_rx_data <= w_sample ? w_rx_nxt : r_rx_sh;
                r_done    <= 1'b1;
            end

            if (r_state == TRAIL && w_state_nxt == IDLE) r_cs_n <= '1;
        end
    end

    assign rx_data = r_rx_data;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule
